uart_pwm_ctrl: RTL and testbench
================================

# uart_pwm_ctrl

Multi-channel successor to the single fixed-width servo path: parses framed pulse-width commands from the UART receiver's byte stream, updates per-channel pulse widths, drives CHANNELS PWM outputs off one shared period counter, and returns an ACK/NAK frame through the UART transmitter's byte interface. It sits between uart_rx/uart_tx and the servo pins in the top level.

## Interface
- CHANNELS, 4: number of PWM outputs (1..256)
- WIDTH_BYTES, 3: pulse-width bytes per frame, MSB first; width field is 8*WIDTH_BYTES bits
- PERIOD, 540000: PWM period in clk cycles (20 ms at 27 MHz); must fit in 8*WIDTH_BYTES bits
- DEFAULT_PULSE, 54054: reset pulse width, all channels
- TIMEOUT_CYCLES, 2700000: inter-byte timeout (only with timeout macro)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_valid  out  1  response byte available
- tx_data  out  8  response byte, stable while tx_valid
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- pin_pwm  out  CHANNELS  PWM outputs
- rx_drop  out  1  one-cycle pulse: byte discarded while response pending

One clock; reset is synchronous and active-high.

## Operation
- Frame: [channel][width MSB … LSB][0x0A], length WIDTH_BYTES+2.
- FSM: IDLE → (rx byte: latch channel) DATA → (WIDTH_BYTES bytes shifted in, byte counter) TERM → (rx byte) RESP_STAT → (handshake) RESP_LF → (handshake) IDLE.
- In TERM: frame valid iff byte == 0x0A, channel < CHANNELS, width <= PERIOD. Valid: write width to channel's pending register, status 0x06. Invalid: no write, status 0x15.
- RESP_STAT drives tx_data = status; RESP_LF drives 0x0A. tx_valid high in both states only; tx_data held until handshake.
- rx bytes arriving in RESP_STAT/RESP_LF are discarded; rx_drop pulses same cycle.
- PWM: counter cnt counts 0..PERIOD-1, wraps to 0. pin_pwm[i] = (cnt < active[i]), registered. Width 0 → constant low; width PERIOD → constant high.
- Pending → active copy for all channels on the cycle cnt wraps to 0; no glitched/partial periods.

## Timing
- Reset: state IDLE, cnt 0, pending = active = DEFAULT_PULSE, pin_pwm 0, tx_valid 0, tx_data 0x00, rx_drop 0.
- tx_valid rises the cycle after the terminator strobe; minimum frame-to-response latency 1 cycle.
- pin_pwm lags cnt compare by 1 cycle; new width visible from the first period starting after the pending write.
- Write and wrap in the same cycle: pending takes new value; active loads the old pending value (new value applies next period).
- Consecutive frames to same channel within one period: last valid one wins.
- rst mid-frame or mid-response: partial frame discarded, response abandoned, all registers to reset values.

## Configuration
- UART_PWM_TIMEOUT_EN defined: in DATA or TERM, a cycle counter restarts on each rx byte; reaching TIMEOUT_CYCLES with no byte returns FSM to IDLE, no write, no response.
- Undefined: no timeout counter; FSM waits indefinitely for the next byte.

## Structure
- Package uart_pwm_pkg: state encoding, STATUS_ACK 0x06, STATUS_NAK 0x15, FRAME_TERM 0x0A.
- Sub-module pwm_bank: shared counter, pending/active registers, registered compare outputs; parser FSM stays in uart_pwm_ctrl.

## Test plan
Bench uses PERIOD=100, DEFAULT_PULSE=10, WIDTH_BYTES=3, CHANNELS=4, TIMEOUT_CYCLES=50.
- Post-reset: pin_pwm each high 10 cycles per 100, all channels aligned; tx_valid 0.
- Frame 02 00 00 32 0A, tx_ready=1 → tx 0x06 then 0x0A; ch2 high 50 cycles from next period; others unchanged.
- Frame 07 00 00 05 0A (bad channel) and 01 00 00 65 0A (width 101) → each yields 0x15, 0x0A; no width change.
- Frame 00 00 00 00 55 (bad terminator) → 0x15, 0x0A; tx_ready held low 20 cycles → tx_data stable, bytes sent meanwhile pulse rx_drop.
- Widths 0 and 100 on ch0/ch1 → constant low/high across wraps; write landing exactly on wrap cycle applies one period later.
- With UART_PWM_TIMEOUT_EN: send 03 00, idle 50 cycles → back to IDLE, no tx; following full frame ACKed. rst mid-frame → reset values restored.

Source files
------------

// File: rtl/uart_pwm_pkg.sv
// Shared types and constants for the UART-commanded multi-channel PWM controller.
package uart_pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_TERM,
    ST_RESP_STAT,
    ST_RESP_LF
  } state_t;

  localparam logic [7:0] STATUS_ACK = 8'h06;
  localparam logic [7:0] STATUS_NAK = 8'h15;
  localparam logic [7:0] FRAME_TERM = 8'h0A;

  // Index width for n entries, never below one bit.
  function automatic int idx_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_pwm_ctrl_if.sv
// Byte-stream link between uart_rx/uart_tx and the PWM controller.
interface uart_pwm_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_drop;

  modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data, rx_drop);
  modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data, rx_drop);
endinterface

// File: rtl/pwm_bank.sv
// Shared period counter, pending/active pulse widths and registered PWM compares.
module pwm_bank
  import uart_pwm_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int WW            = 24,
  parameter int PERIOD        = 540000,
  parameter int DEFAULT_PULSE = 54054,
  parameter int CH_W          = idx_bits(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [WW-1:0]       wr_width,
  output logic [CHANNELS-1:0] pin_pwm
);

  localparam logic [WW-1:0] LAST = WW'(PERIOD - 1);
  localparam logic [WW-1:0] DEF  = WW'(DEFAULT_PULSE);

  logic [WW-1:0] cnt;
  logic [WW-1:0] pending [CHANNELS];
  logic [WW-1:0] active  [CHANNELS];
  logic          wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pin_pwm <= '0;
      // NOTE: these width arrays are reset element by element because every channel must restart at a known pulse width; plain storage arrays normally stay unreset.
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= DEF;
        active[i]  <= DEF;
      end
    end else begin
      cnt <= wrap ? '0 : cnt + WW'(1);
      // NOTE: non-blocking assignments make a write on the wrap cycle land in pending while active still copies the old pending value.
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrap) active[i] <= pending[i];
        pin_pwm[i] <= (cnt < active[i]);
      end
      if (wr_en) pending[wr_chan] <= wr_width;
    end
  end

endmodule

// File: rtl/uart_pwm_ctrl.sv
// Frame parser and ACK/NAK responder feeding pwm_bank.
// Optional inter-byte timeout enabled by defining UART_PWM_TIMEOUT_EN.
module uart_pwm_ctrl
  import uart_pwm_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int WIDTH_BYTES    = 3,
  parameter int PERIOD         = 540000,
  parameter int DEFAULT_PULSE  = 54054,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic                clk,
  input  logic                rst,
  uart_pwm_ctrl_if.slave      bus,
  output logic [CHANNELS-1:0] pin_pwm
);

  localparam int WW   = 8 * WIDTH_BYTES;
  localparam int CH_W = idx_bits(CHANNELS);
  localparam int BC_W = idx_bits(WIDTH_BYTES);

  state_t          state, state_d;
  logic [7:0]      chan;
  logic [WW-1:0]   width_sr;
  logic [BC_W-1:0] byte_cnt;
  logic [7:0]      status;
  logic            frame_ok;
  logic            wr_en;
  logic            timeout;
  logic            tx_valid, rx_drop;
  logic [7:0]      tx_data;

  assign frame_ok = (bus.rx_data == FRAME_TERM) &&
                    ({1'b0, chan} < 9'(CHANNELS)) &&
                    (width_sr <= WW'(PERIOD));

`ifdef UART_PWM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts idle cycles since the last byte while a frame is partially received.
  always_ff @(posedge clk) begin
    if (rst || bus.rx_valid || !(state == ST_DATA || state == ST_TERM))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !bus.rx_valid;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    state_d  = state;
    wr_en    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_drop  = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.rx_valid) state_d = ST_DATA;
      ST_DATA: begin
        if (timeout) state_d = ST_IDLE;
        else if (bus.rx_valid && byte_cnt == BC_W'(WIDTH_BYTES - 1)) state_d = ST_TERM;
      end
      ST_TERM: begin
        if (timeout) state_d = ST_IDLE;
        else if (bus.rx_valid) begin
          wr_en   = frame_ok;
          state_d = ST_RESP_STAT;
        end
      end
      ST_RESP_STAT: begin
        tx_valid = 1'b1;
        tx_data  = status;
        rx_drop  = bus.rx_valid;
        if (bus.tx_ready) state_d = ST_RESP_LF;
      end
      ST_RESP_LF: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_TERM;
        rx_drop  = bus.rx_valid;
        if (bus.tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan     <= '0;
      width_sr <= '0;
      byte_cnt <= '0;
      status   <= '0;
    end else if (bus.rx_valid) begin
      if (state == ST_IDLE) begin
        chan     <= bus.rx_data;
        byte_cnt <= '0;
      end
      if (state == ST_DATA) begin
        width_sr <= (width_sr << 8) | WW'(bus.rx_data);
        byte_cnt <= byte_cnt + BC_W'(1);
      end
      if (state == ST_TERM) status <= frame_ok ? STATUS_ACK : STATUS_NAK;
    end
  end

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data;
  assign bus.rx_drop  = rx_drop;

  pwm_bank #(
    .CHANNELS     (CHANNELS),
    .WW           (WW),
    .PERIOD       (PERIOD),
    .DEFAULT_PULSE(DEFAULT_PULSE),
    .CH_W         (CH_W)
  ) u_pwm_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_chan (chan[CH_W-1:0]),
    .wr_width(width_sr),
    .pin_pwm (pin_pwm)
  );

endmodule

// File: tb/tb_uart_pwm_ctrl.sv
// Randomized bench for uart_pwm_ctrl against a timeline-based model of writes and periods.
module tb_uart_pwm_ctrl;
  import uart_pwm_pkg::*;

  localparam int P   = 100;
  localparam int DEF = 10;
  localparam int WB  = 3;
  localparam int CH  = 4;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] pin_pwm;
  always #5 clk = ~clk;

  uart_pwm_ctrl_if bus ();

  uart_pwm_ctrl #(
    .CHANNELS(CH), .WIDTH_BYTES(WB), .PERIOD(P), .DEFAULT_PULSE(DEF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pin_pwm(pin_pwm)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: accepted writes stamped with the clock edge that sampled their terminator,
  // plus the response bytes still owed to the transmitter.
  typedef struct { int stamp; int ch; int width; } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  int         n_edge = 0;
  bit         rand_ready = 0;

  always @(posedge clk) begin
    if (rst) n_edge <= 0;
    else     n_edge <= n_edge + 1;
  end

  // Output after edge m shows phase (m-1)%P of the period starting at edge s;
  // that period uses the widths written strictly before edge s.
  function automatic logic [CH-1:0] exp_pin(int m);
    logic [CH-1:0] r = '0;
    int c, s, w;
    if (m == 0) return '0;
    c = (m - 1) % P;
    s = P * ((m - 1) / P);
    for (int ch = 0; ch < CH; ch++) begin
      w = DEF;
      foreach (wq[j]) if (wq[j].ch == ch && wq[j].stamp < s) w = wq[j].width;
      r[ch] = (c < w);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("pwm", 32'(pin_pwm), 32'(exp_pin(n_edge)));
      check("tx_valid", 32'(bus.tx_valid), 32'(rq.size() > 0));
      check("rx_drop", 32'(bus.rx_drop), 32'(bus.rx_valid && rq.size() > 0));
      if (rq.size() > 0) begin
        check("tx_data", 32'(bus.tx_data), 32'(rq[0]));
        if (bus.tx_ready) void'(rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_resp_done();
    for (int i = 0; i < 400 && rq.size() > 0; i++) tick();
    if (rq.size() > 0) begin
      check("resp_done", 32'(rq.size()), 32'd0);
      rq.delete();
    end
  endtask

  task automatic send_frame(int ch, int width, logic [7:0] term, bit gaps);
    bit ok;
    wait_resp_done();
    send_byte(8'(ch));
    for (int k = WB - 1; k >= 0; k--) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_byte(8'(width >> (8 * k)));
    end
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    send_byte(term);
    ok = (term == 8'h0A) && (ch < CH) && (width <= P);
    if (ok) wq.push_back('{n_edge, ch, width});
    rq.push_back(ok ? 8'h06 : 8'h15);
    rq.push_back(8'h0A);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    rq.delete();
    wq.delete();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_pin", 32'(pin_pwm), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_rx_drop", 32'(bus.rx_drop), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    do_reset();
    repeat (250) tick();

    // Valid write, then bad channel and over-range width.
    send_frame(2, 50, 8'h0A, 0);
    repeat (250) tick();
    send_frame(7, 5, 8'h0A, 0);
    send_frame(1, 101, 8'h0A, 0);
    wait_resp_done();
    repeat (120) tick();

    // Bad terminator with the transmitter stalled; extra bytes must be dropped.
    bus.tx_ready = 1'b0;
    send_frame(0, 0, 8'h55, 0);
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 2) send_byte(8'($urandom));
      else tick();
    end
    bus.tx_ready = 1'b1;
    wait_resp_done();

    // Extreme widths, then a write whose terminator lands exactly on the wrap edge.
    send_frame(0, 0, 8'h0A, 0);
    send_frame(1, P, 8'h0A, 0);
    wait_resp_done();
    repeat (250) tick();
    for (int i = 0; i < 2 * P && ((n_edge + 5) % P) != 0; i++) tick();
    send_frame(3, 77, 8'h0A, 0);
    repeat (250) tick();

    // Randomized frames with random gaps and transmitter back-pressure.
    rand_ready = 1;
    repeat (20) begin
      int ch, w, sel;
      logic [7:0] term;
      ch  = $urandom_range(0, 5);
      sel = $urandom_range(0, 3);
      w   = (sel == 0) ? 0 : (sel == 1) ? P : (sel == 2) ? $urandom_range(0, P + 10) : P + 1;
      term = ($urandom_range(0, 7) == 0) ? 8'h55 : 8'h0A;
      send_frame(ch, w, term, 1);
      repeat ($urandom_range(0, 150)) tick();
    end
    wait_resp_done();
    rand_ready = 0;
    bus.tx_ready = 1'b1;
    repeat (5) tick();

`ifdef UART_PWM_TIMEOUT_EN
    // Abandoned partial frame is dropped after the idle timeout.
    send_byte(8'h03);
    send_byte(8'h00);
    repeat (TO + 10) tick();
    send_frame(3, 40, 8'h0A, 0);
    wait_resp_done();
    repeat (150) tick();
`endif

    // Reset mid-frame, then a full frame must parse from scratch.
    send_byte(8'h02);
    send_byte(8'h00);
    do_reset();
    send_frame(2, 60, 8'h0A, 0);
    wait_resp_done();
    repeat (150) tick();

    // Reset mid-response abandons the pending reply.
    bus.tx_ready = 1'b0;
    send_frame(1, 30, 8'h0A, 0);
    repeat (3) tick();
    do_reset();
    bus.tx_ready = 1'b1;
    repeat (220) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
